// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared types for the gelato instruction-fetch scheduler.
// WARP_NUM is a compile-time macro (default 4); define it on the command
// line to change the warp count.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

package gelato_types;

    localparam int NUM_WARPS         = `WARP_NUM;
    localparam int WARP_W            = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int SPLIT_TABLE_NUM_W = 4;

    typedef logic [31:0]                  addr_t;
    typedef logic [31:0]                  inst_t;
    typedef logic [SPLIT_TABLE_NUM_W-1:0] split_table_num_t;
    typedef logic [WARP_W-1:0]            warp_num_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } fetch_state_e;

    // (base + off) mod NUM_WARPS, valid for off in [0, NUM_WARPS)
    function automatic warp_num_t wrap_idx(input warp_num_t base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_WARPS) begin
            sum = sum - NUM_WARPS;
        end
        return warp_num_t'(sum);
    endfunction

endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// I-cache request/response, decode handshake and PC-table acknowledge bundle.
// master = fetch scheduler, slave = I-cache / decode / PC-table side.
interface gelato_fetch_scheduler_if;
    import gelato_types::*;

    logic             icache_req_valid;
    logic             icache_req_ready;
    addr_t            icache_req_addr;
    logic             icache_rsp_valid;
    inst_t            icache_rsp_inst;
    logic             inst_valid;
    logic             inst_ready;
    inst_t            inst;
    addr_t            inst_pc;
    warp_num_t        inst_warp;
    split_table_num_t inst_split_table_num;
    logic             pctable_ack;
    warp_num_t        pctable_ack_warp;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_inst,
        output inst_valid, inst, inst_pc, inst_warp, inst_split_table_num,
        input  inst_ready,
        output pctable_ack, pctable_ack_warp
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_inst,
        input  inst_valid, inst, inst_pc, inst_warp, inst_split_table_num,
        output inst_ready,
        input  pctable_ack, pctable_ack_warp
    );

endinterface

// File: rtl/gelato_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting warp found
// scanning upward from rr_ptr with wrap-around.
module gelato_rr_arbiter
    import gelato_types::*;
(
    input  logic [NUM_WARPS-1:0] req,
    input  warp_num_t            rr_ptr,
    output logic                 grant_valid,
    output warp_num_t            grant_idx
);

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_WARPS - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Instruction-fetch scheduler: round-robin picks a ready warp, issues one
// outstanding I-cache request, forwards the instruction to decode and acks
// the PC table on acceptance.
// Optional feature: GELATO_FETCH_PERF_EN builds the fetch/stall counters;
// without it the perf ports are tied to zero.
module gelato_fetch_scheduler
    import gelato_types::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WARPS-1:0]     valid,
    input  addr_t                    pc              [NUM_WARPS],
    input  split_table_num_t         split_table_num [NUM_WARPS],
    input  logic [NUM_WARPS-1:0]     flush,
    gelato_fetch_scheduler_if.master bus,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt
);

    fetch_state_e         state_q;
    warp_num_t            rr_ptr_q;
    warp_num_t            warp_q;
    addr_t                pc_q;
    split_table_num_t     split_q;
    inst_t                inst_q;
    logic                 kill_q;

    logic [NUM_WARPS-1:0] cand;
    logic                 grant_valid;
    warp_num_t            grant_idx;
    logic                 flush_cur;
    logic                 out_live;

    // A warp is a fetch candidate only when its PC is valid and not redirecting
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_cand
        assign cand[gi] = valid[gi] && !flush[gi];
    end

    gelato_rr_arbiter u_arb (
        .req         (cand),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign flush_cur = flush[warp_q];
    // A flush of the latched warp suppresses the presented instruction at once
    assign out_live  = (state_q == OUT) && !flush_cur;

    assign bus.icache_req_valid     = (state_q == REQ);
    assign bus.icache_req_addr      = pc_q;
    assign bus.inst_valid           = out_live;
    assign bus.inst                 = inst_q;
    assign bus.inst_pc              = pc_q;
    assign bus.inst_warp            = warp_q;
    assign bus.inst_split_table_num = split_q;
    assign bus.pctable_ack          = out_live && bus.inst_ready;
    assign bus.pctable_ack_warp     = warp_q;

    // Fetch FSM: grant, request, wait for response, present to decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            warp_q   <= '0;
            pc_q     <= '0;
            split_q  <= '0;
            inst_q   <= '0;
            kill_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        warp_q  <= grant_idx;
                        pc_q    <= pc[grant_idx];
                        split_q <= split_table_num[grant_idx];
                        kill_q  <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // Request stays raised even when killed; only the response is dropped
                    if (flush_cur) begin
                        kill_q <= 1'b1;
                    end
                    if (bus.icache_req_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.icache_rsp_valid) begin
                        if (kill_q || flush_cur) begin
                            state_q <= IDLE;
                        end else begin
                            inst_q  <= bus.icache_rsp_inst;
                            state_q <= OUT;
                        end
                    end else if (flush_cur) begin
                        kill_q <= 1'b1;
                    end
                end
                OUT: begin
                    // Killed fetches leave rr_ptr alone so the warp is retried first
                    if (flush_cur) begin
                        state_q <= IDLE;
                    end else if (bus.inst_ready) begin
                        rr_ptr_q <= wrap_idx(warp_q, 1);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GELATO_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Free-running wrap-around counters of completed fetches and stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.pctable_ack) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((bus.icache_req_valid && !bus.icache_req_ready) ||
                ((state_q == WAIT) && !bus.icache_rsp_valid)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
